vga_sync_gen: RTL and testbench

//   Output stage fed by the horizontal/vertical VGA counter pair (h: 0..799, v: 0..524).

---
 rtl/vga_sync_gen.sv | 203 ++++++++++++++++++++
 tb/tb_vga_sync_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Output stage behind an upstream horizontal/vertical VGA counter pair.
//   Decodes the raw counts into sync / display-enable, issues pixel fetch
//   coordinates one tick later, and delays the syncs so they line up with the
//   pixel data returned by a PIPE-tick pixel source. A vertical-region FSM
//   shadows the counters and raises a sticky error on any inconsistency.
//
// Ports
//   clk          pixel-domain clock
//   reset_n      asynchronous active-low reset (released synchronously inside)
//   pix_en       pixel tick; all state advances only when high
//   h_cnt/v_cnt  upstream horizontal / vertical counts
//   rgb_in       pixel data {R4,G4,B4}, valid PIPE ticks after pix_req
//   pix_req      fetch request: (pix_x, pix_y) is a visible pixel
//   pix_x/pix_y  fetch coordinates (counts registered once)
//   hsync/vsync  syncs aligned with rgb_out, active level SYNC_POL
//   rgb_out      displayed pixel, 0 while blanked
//   frame_start  one-clk pulse when stage 1 holds (0,0)
//   line_start   one-clk pulse when stage 1 holds h=0 on a visible line
//   cnt_err      sticky counter-consistency error
// -----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_en,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [11:0] rgb_in,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        line_start,
    output logic        cnt_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] H_HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_TOT_C   = 10'(H_TOTAL);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] V_VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_TOT_C   = 10'(V_TOTAL);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SY_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_ACT  = 2'd0,
        ST_FP   = 2'd1,
        ST_SYNC = 2'd2,
        ST_BP   = 2'd3
    } vregion_t;

    // Sync/enable tap travelling alongside the pixel request.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } tap_t;

    // ------------------------------------------------------------------
    // Reset release synchroniser: assertion is immediate, release is
    // aligned to clk so no flop sees reset removal near an edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    // ------------------------------------------------------------------
    // Stage-1 decode of the raw counts (no masking on bad counts).
    // ------------------------------------------------------------------
    tap_t tap_in;

    assign tap_in.de = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign tap_in.hs = (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
    assign tap_in.vs = (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);

    // dly[0] is stage 1; dly[PIPE-1] feeds the output register, giving
    // PIPE ticks from pix_req to rgb_out.
    tap_t dly [PIPE];

    assign pix_req = dly[0].de;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            rgb_out     <= '0;
            // NOTE: the delay line is only PIPE x 3 flops, so it is reset
            // explicitly; otherwise stale syncs would leak out after reset.
            for (int i = 0; i < PIPE; i++) begin
                dly[i] <= '0;
            end
        end else if (pix_en) begin
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            line_start  <= (h_cnt == '0) && (v_cnt < V_ACT_C);
            dly[0]      <= tap_in;
            for (int i = 1; i < PIPE; i++) begin
                dly[i] <= dly[i-1];
            end
            hsync   <= dly[PIPE-1].hs ? SYNC_POL : ~SYNC_POL;
            vsync   <= dly[PIPE-1].vs ? SYNC_POL : ~SYNC_POL;
            rgb_out <= dly[PIPE-1].de ? rgb_in : 12'h000;
        end else begin
            // Pulses mark a tick, so they never stretch across idle clocks.
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Vertical-region FSM cross-checking the counters.
    // ------------------------------------------------------------------
    vregion_t state_q, state_d, v_region, base;
    logic     mismatch;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        v_region = ST_ACT;
        if (v_cnt < V_ACT_C) begin
            v_region = ST_ACT;
        end else if (v_cnt < V_VS_BEG) begin
            v_region = ST_FP;
        end else if (v_cnt < V_VS_END) begin
            v_region = ST_SYNC;
        end else if (v_cnt < V_TOT_C) begin
            v_region = ST_BP;
        end

        mismatch = (v_region != state_q) || (h_cnt >= H_TOT_C) || (v_cnt >= V_TOT_C);

        // On a mismatch the FSM resynchronises to the decoded region; the
        // end-of-line advance then applies from that corrected region.
        base    = mismatch ? v_region : state_q;
        state_d = state_q;

        if (pix_en) begin
            state_d = base;
            if (h_cnt == H_LAST) begin
                unique case (base)
                    ST_ACT:  if (v_cnt == V_ACT_END) state_d = ST_FP;
                    ST_FP:   if (v_cnt == V_FP_END)  state_d = ST_SYNC;
                    ST_SYNC: if (v_cnt == V_SY_END)  state_d = ST_BP;
                    ST_BP:   if (v_cnt == V_LAST)    state_d = ST_ACT;
                    default: state_d = ST_ACT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACT;
            cnt_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pix_en && mismatch) begin
                cnt_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Self-checking bench for vga_sync_gen. A reference model computes every
//   expected output from the timing rules with plain arithmetic: syncs and
//   enable from the counts presented PIPE ticks earlier, the expected vertical
//   region from the previous tick's counts.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam bit SYNC_POL = 1'b0;
    localparam int PIPE     = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_PRINT = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic [11:0] rgb_in = '0;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb_out;
    logic        frame_start;
    logic        line_start;
    logic        cnt_err;

    int checks = 0;
    int errors = 0;

    vga_sync_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .PIPE(PIPE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .rgb_in(rgb_in),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out),
        .frame_start(frame_start), .line_start(line_start), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] h;
    } tap_t;

    tap_t        dq[$];
    int          exp_region;
    logic        exp_req, exp_hs, exp_vs, exp_fs, exp_ls, exp_err;
    logic [9:0]  exp_x, exp_y;
    logic [11:0] exp_rgb;

    function automatic tap_t decode(int h, int v);
        tap_t t;
        t.hs = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
        t.vs = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
        t.de = (h < H_ACTIVE) && (v < V_ACTIVE);
        t.h  = h[9:0];
        return t;
    endfunction

    // 0 active, 1 front porch, 2 sync, 3 back porch; out of range counts as active.
    function automatic int region(int v);
        if (v < V_ACTIVE) return 0;
        if (v < V_ACTIVE + V_FP) return 1;
        if (v < V_ACTIVE + V_FP + V_SYNC) return 2;
        if (v < V_TOTAL) return 3;
        return 0;
    endfunction

    function automatic logic [37:0] exp_vec();
        return {exp_req, exp_x, exp_y, exp_hs, exp_vs, exp_rgb, exp_fs, exp_ls, exp_err};
    endfunction

    function automatic logic [37:0] obs_vec();
        return {pix_req, pix_x, pix_y, hsync, vsync, rgb_out, frame_start, line_start, cnt_err};
    endfunction

    task automatic model_reset();
        dq.delete();
        repeat (PIPE) dq.push_back('0);
        exp_region = 0;
        exp_req = 1'b0; exp_x = '0; exp_y = '0;
        exp_hs = ~SYNC_POL; exp_vs = ~SYNC_POL;
        exp_rgb = '0; exp_fs = 1'b0; exp_ls = 1'b0; exp_err = 1'b0;
    endtask

    // Drive one clock (inputs at negedge), then advance the model just after
    // the rising edge. With pat set, rgb_in carries the fetched column pattern.
    task automatic step(input bit en, input int h, input int v, input bit pat,
                        input logic [11:0] rnd);
        tap_t        old;
        tap_t        cur;
        logic [11:0] rgb;
        old = dq[0];
        rgb = pat ? {3{old.h[3:0]}} : rnd;
        @(negedge clk);
        pix_en = en;
        h_cnt  = h[9:0];
        v_cnt  = v[9:0];
        rgb_in = rgb;
        @(posedge clk);
        #1;
        if (en) begin
            cur = decode(h, v);
            dq.push_back(cur);
            old = dq.pop_front();
            exp_x   = h[9:0];
            exp_y   = v[9:0];
            exp_req = cur.de;
            exp_hs  = old.hs ? SYNC_POL : ~SYNC_POL;
            exp_vs  = old.vs ? SYNC_POL : ~SYNC_POL;
            exp_rgb = old.de ? rgb : 12'h000;
            exp_fs  = (h == 0) && (v == 0);
            exp_ls  = (h == 0) && (v < V_ACTIVE);
            if (region(v) != exp_region || h >= H_TOTAL || v >= V_TOTAL) exp_err = 1'b1;
            if (v >= V_TOTAL) exp_region = 0;
            else if (h == H_TOTAL - 1) exp_region = region((v + 1) % V_TOTAL);
            else exp_region = region(v);
        end else begin
            exp_fs = 1'b0;
            exp_ls = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pix_en  = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        repeat (3) step(1'b0, 0, 0, 1'b0, 12'h000);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        model_reset();
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vsync); end
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb_out); end
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL reset_cnt_err got %b exp 0", cnt_err); end
        checks++; if (pix_req !== 1'b0) begin errors++; $display("FAIL reset_pix_req got %b exp 0", pix_req); end
        checks++; if (frame_start !== 1'b0 || line_start !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got %b%b exp 00", frame_start, line_start);
        end
        checks++; if ({pix_x, pix_y} !== 20'h0) begin errors++; $display("FAIL reset_xy got %h exp 0", {pix_x, pix_y}); end
        apply_reset();
        checks++; if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_release got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    // Free run from reset through the vertical sync and the frame wrap.
    task automatic test_free_run();
        int lines = 0;
        int v     = V_ACTIVE - 4;
        int low, first_low;
        apply_reset();
        while (lines < 52) begin
            low = 0;
            first_low = -1;
            for (int h = 0; h < H_TOTAL; h++) begin
                step(1'b1, h, v, 1'b1, 12'h000);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    if (errors < MAX_PRINT) $display("FAIL free_run h=%0d v=%0d got %h exp %h", h, v, obs_vec(), exp_vec());
                end
                if (hsync == SYNC_POL) begin
                    low++;
                    if (first_low < 0) first_low = h;
                end
                if (h == 3 && v < V_ACTIVE) begin
                    checks++; if (rgb_out !== 12'h111) begin errors++; $display("FAIL first_pixel v=%0d got %h exp 111", v, rgb_out); end
                end
                if (h == H_ACTIVE + 2) begin
                    checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL blank_edge v=%0d got %h exp 000", v, rgb_out); end
                end
                if (h == 400) begin
                    checks++;
                    if (vsync !== ((v == 490 || v == 491) ? SYNC_POL : ~SYNC_POL)) begin
                        errors++; $display("FAIL vsync_line v=%0d got %b", v, vsync);
                    end
                end
            end
            checks++; if (low != H_SYNC) begin errors++; $display("FAIL hsync_width v=%0d got %0d exp %0d", v, low, H_SYNC); end
            checks++; if (first_low != H_ACTIVE + H_FP + PIPE) begin
                errors++; $display("FAIL hsync_start v=%0d got %0d exp %0d", v, first_low, H_ACTIVE + H_FP + PIPE);
            end
            v = (v + 1) % V_TOTAL;
            lines++;
        end
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL free_run_err got %b exp 0", cnt_err); end
    endtask

    // pix_en high one clock in four, across the frame wrap.
    task automatic test_pix_en_toggle();
        int h = 600, v = V_TOTAL - 1, fs_clks = 0;
        apply_reset();
        for (int i = 0; i < 1600; i++) begin
            step((i % 4) == 0, h, v, 1'b0, 12'($urandom));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (errors < MAX_PRINT) $display("FAIL en_toggle i=%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            if (frame_start) fs_clks++;
            if ((i % 4) == 0) begin
                if (h == H_TOTAL - 1) begin h = 0; v = (v + 1) % V_TOTAL; end
                else h++;
            end
        end
        checks++; if (fs_clks != 1) begin errors++; $display("FAIL frame_start_width got %0d exp 1", fs_clks); end
    endtask

    // Vertical jump from line 100 into the front porch.
    task automatic test_v_jump();
        apply_reset();
        for (int h = 0; h < 400; h++) step(1'b1, h, 100, 1'b0, 12'hABC);
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL v_jump_pre got %b exp 0", cnt_err); end
        step(1'b1, 400, 485, 1'b0, 12'hABC);
        checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL v_jump_err got %b exp 1", cnt_err); end
        for (int h = 401; h < H_TOTAL; h++) begin
            step(1'b1, h, 485, 1'b0, 12'h5A5);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (errors < MAX_PRINT) $display("FAIL v_jump_follow h=%0d got %h exp %h", h, obs_vec(), exp_vec());
            end
        end
        checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL v_jump_sticky got %b exp 1", cnt_err); end
    endtask

    // One tick of h_cnt=800 on a visible line.
    task automatic test_h_overflow();
        apply_reset();
        for (int h = 620; h < 640; h++) step(1'b1, h, 10, 1'b0, 12'h777);
        step(1'b1, H_TOTAL, 10, 1'b0, 12'h777);
        checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL h_ovf_err got %b exp 1", cnt_err); end
        checks++; if (pix_req !== 1'b0) begin errors++; $display("FAIL h_ovf_req got %b exp 0", pix_req); end
        checks++; if (pix_x !== 10'd800) begin errors++; $display("FAIL h_ovf_x got %0d exp 800", pix_x); end
        for (int i = 0; i < PIPE; i++) begin
            step(1'b1, 641 + i, 10, 1'b0, 12'h777);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL h_ovf_follow i=%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        checks++; if (hsync !== ~SYNC_POL) begin errors++; $display("FAIL h_ovf_hsync got %b exp %b", hsync, ~SYNC_POL); end
    endtask

    // Random counts, random pix_en, occasional jumps (some out of range).
    task automatic test_random();
        int h = 780, v = V_ACTIVE - 2;
        bit en;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end else if ($urandom_range(0, 199) == 0) begin
                v = $urandom_range(0, V_TOTAL - 1);
            end
            step(en, h, v, 1'b0, 12'($urandom));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (errors < MAX_PRINT) $display("FAIL random i=%0d h=%0d v=%0d got %h exp %h", i, h, v, obs_vec(), exp_vec());
            end
            if (en) begin
                if (h >= H_TOTAL - 1) begin h = 0; v = (v >= V_TOTAL - 1) ? 0 : v + 1; end
                else h++;
            end
        end
    endtask

    // Reset asserted mid-line while both syncs are active.
    task automatic test_async_reset();
        apply_reset();
        for (int h = 650; h <= 700; h++) step(1'b1, h, 491, 1'b0, 12'hFFF);
        checks++; if (hsync !== SYNC_POL || vsync !== SYNC_POL) begin
            errors++; $display("FAIL pre_reset_syncs got %b%b exp active", hsync, vsync);
        end
        checks++; if (cnt_err !== 1'b1) begin errors++; $display("FAIL pre_reset_err got %b exp 1", cnt_err); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (hsync !== ~SYNC_POL) begin errors++; $display("FAIL async_hsync got %b exp %b", hsync, ~SYNC_POL); end
        checks++; if (vsync !== ~SYNC_POL) begin errors++; $display("FAIL async_vsync got %b exp %b", vsync, ~SYNC_POL); end
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL async_rgb got %h exp 000", rgb_out); end
        checks++; if (cnt_err !== 1'b0) begin errors++; $display("FAIL async_err got %b exp 0", cnt_err); end
        apply_reset();
        // Counts restarting at (0,0) agree with the reset FSM state.
        for (int h = 0; h < 40; h++) step(1'b1, h, 0, 1'b0, 12'h123);
        checks++; if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL restart got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_pix_en_toggle();
        test_v_jump();
        test_h_overflow();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
